// File: rtl/accum_sequencer.sv
// Multi-operand accumulator controller: feeds an external adder with the running total
// and the incoming operand, registers its sum, and presents the final total with a sticky overflow.
module accum_sequencer #(
  parameter int WIDTH = 5,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] num_ops,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  output logic             add_cin,
  input  logic [WIDTH-1:0] add_sum,
  input  logic             add_cout,
  output logic [WIDTH-1:0] result,
  output logic             overflow,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] ops_l;
  logic             ovf;
  logic             transfer;

  assign transfer = in_valid & in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      acc   <= '0;
      cnt   <= '0;
      ops_l <= '0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            acc <= '0;
            ovf <= 1'b0;
            if (num_ops != '0) begin
              cnt   <= '0;
              ops_l <= num_ops;
              state <= RUN;
            end else begin
              // An empty run still produces a (zero) result handshake.
              state <= DONE;
            end
          end
        end
        RUN: begin
          if (transfer) begin
            acc <= add_sum;
            ovf <= ovf | add_cout;
            cnt <= cnt + CNT_W'(1);
            if (cnt == ops_l - CNT_W'(1)) begin
              state <= DONE;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // All outputs decode straight from registers; only add_b is a pass-through.
  assign in_ready  = (state == RUN);
  assign out_valid = (state == DONE);
  assign busy      = (state == RUN) || (state == DONE);
  assign result    = acc;
  assign overflow  = ovf;
  assign add_a     = acc;
  assign add_b     = in_data;
  assign add_cin   = 1'b0;

endmodule
